// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer for the EX stage.
// Single-shot multiply and radix-2 restoring divide.
module muldiv_sequencer #(
   parameter int XLEN       = 32,
   parameter int MUL_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW  = $clog2(XLEN);
   localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t          state;
   logic [1:0]      op;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic [MCW-1:0]  mul_cnt;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] quot;
   logic [XLEN-1:0] divisor;
   logic [CW-1:0]   cnt;
   logic            neg_q;
   logic            neg_r;

   logic            accept;
   logic            in_signed;
   logic            in_rem;
   logic            b_zero;
   logic            ovf;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;

   assign accept    = start & ~flush & ((state == IDLE) | (state == DONE));
   assign in_signed = ~funct3[0];
   assign in_rem    = funct3[1];
   assign b_zero    = (rs2_val == '0);
   assign ovf       = in_signed
                    & (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                    & (rs2_val == '1);
   assign abs_a     = (in_signed & rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
   assign abs_b     = (in_signed & rs2_val[XLEN-1]) ? -rs2_val : rs2_val;

   // Operands are sign- or zero-extended so one unsigned multiply
   // yields the correct upper half for every variant.
   logic              sa;
   logic              sb;
   logic [2*XLEN-1:0] ma;
   logic [2*XLEN-1:0] mb;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   mul_res;

   assign sa      = (op[1] ^ op[0]) & a_q[XLEN-1];
   assign sb      = (op == 2'b01) & b_q[XLEN-1];
   assign ma      = {{XLEN{sa}}, a_q};
   assign mb      = {{XLEN{sb}}, b_q};
   assign prod    = ma * mb;
   assign mul_res = (op == 2'b00) ? prod[XLEN-1:0]
                                  : prod[2*XLEN-1:XLEN];

   // The shifted partial remainder needs one extra bit so divisors
   // with the msb set compare correctly.
   logic [XLEN:0]   sh;
   logic            ge;
   logic [XLEN-1:0] rem_nx;
   logic [XLEN-1:0] quot_nx;
   logic [XLEN-1:0] q_fix;
   logic [XLEN-1:0] r_fix;
   logic [XLEN-1:0] div_res;

   assign sh      = {rem, quot[XLEN-1]};
   assign ge      = sh >= {1'b0, divisor};
   assign rem_nx  = ge ? (sh[XLEN-1:0] - divisor) : sh[XLEN-1:0];
   assign quot_nx = {quot[XLEN-2:0], ge};
   assign q_fix   = neg_q ? -quot_nx : quot_nx;
   assign r_fix   = neg_r ? -rem_nx : rem_nx;
   assign div_res = op[1] ? r_fix : q_fix;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         op      <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mul_cnt <= '0;
         rem     <= '0;
         quot    <= '0;
         divisor <= '0;
         cnt     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
      end else if (flush) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               if (accept) begin
                  op  <= funct3[1:0];
                  a_q <= rs1_val;
                  b_q <= rs2_val;
                  if (!funct3[2]) begin
                     state   <= MUL;
                     busy    <= 1'b1;
                     mul_cnt <= MCW'(MUL_CYCLES - 1);
                  end else if (b_zero) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     result <= in_rem ? rs1_val : '1;
                  end else if (ovf) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     result <= in_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                  end else begin
                     state   <= DIV;
                     busy    <= 1'b1;
                     rem     <= '0;
                     quot    <= abs_a;
                     divisor <= abs_b;
                     cnt     <= CW'(XLEN - 1);
                     neg_q   <= in_signed & (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
                     neg_r   <= in_signed & rs1_val[XLEN-1];
                  end
               end
            end
            MUL: begin
               if (mul_cnt == '0) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= mul_res;
               end else begin
                  mul_cnt <= mul_cnt - 1'b1;
               end
            end
            DIV: begin
               rem  <= rem_nx;
               quot <= quot_nx;
               cnt  <= cnt - 1'b1;
               if (cnt == '0) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= div_res;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus
// hand-written flush, back-to-back and reset sequences.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;

   muldiv_sequencer #(.XLEN(32), .MUL_CYCLES(1)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .funct3  (funct3),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
      int          bcnt;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs[NV];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Issues one op and waits for done; lat counts cycles after the
   // accepting edge, bcnt counts cycles with busy high.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, output int lat,
                         output int bcnt);
      funct3  = f;
      rs1_val = a;
      rs2_val = b;
      start   = 1'b1;
      tick();
      start = 1'b0;
      lat   = 1;
      bcnt  = 0;
      while (!done && lat < 60) begin
         if (busy) bcnt++;
         tick();
         lat++;
      end
   endtask

   task automatic setv(input int i, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res);
      vecs[i].f    = f;
      vecs[i].a    = a;
      vecs[i].b    = b;
      vecs[i].res  = res;
      vecs[i].lat  = f[2] ? 33 : 2;
      vecs[i].bcnt = f[2] ? 32 : 1;
   endtask

   initial begin
      int lat;
      int bcnt;
      logic [31:0] keep;
      logic seen;

      setv(0,  3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
      setv(1,  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      setv(2,  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      setv(3,  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      setv(4,  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
      setv(5,  3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
      setv(6,  3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
      setv(7,  3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
      setv(8,  3'b101, 32'd100,       32'd7,         32'd14);
      setv(9,  3'b111, 32'd100,       32'd7,         32'd2);
      setv(10, 3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001);
      setv(11, 3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE);
      setv(12, 3'b100, 32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD);
      setv(13, 3'b110, 32'd20,        32'hFFFF_FFFA, 32'd2);
      setv(14, 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
      setv(15, 3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF);
      setv(16, 3'b111, 32'd5,         32'd0,         32'd5);
      setv(17, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      setv(18, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
      setv(19, 3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF);
      for (int i = 15; i < NV; i++) begin
         vecs[i].lat  = 1;
         vecs[i].bcnt = 0;
      end

      rst     = 1'b1;
      start   = 1'b0;
      flush   = 1'b0;
      funct3  = '0;
      rs1_val = '0;
      rs2_val = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_result", result, 32'd0);

      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].f, vecs[i].a, vecs[i].b, lat, bcnt);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].bcnt);
         chk($sformatf("v%0d_result", i), result, vecs[i].res);
         chk($sformatf("v%0d_busy_at_done", i), {31'b0, busy}, 32'd0);
         tick();
         chk($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
      end

      // Flush ten edges into a divide.
      keep    = result;
      funct3  = 3'b101;
      rs1_val = 32'd100;
      rs2_val = 32'd7;
      start   = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k < 10; k++) tick();
      chk("flush_busy_before", {31'b0, busy}, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy_after", {31'b0, busy}, 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done || busy) seen = 1'b1;
         tick();
      end
      chk("flush_no_done", {31'b0, seen}, 32'd0);
      chk("flush_result_kept", result, keep);

      // Start and flush together in IDLE.
      funct3  = 3'b000;
      rs1_val = 32'd3;
      rs2_val = 32'd4;
      start   = 1'b1;
      flush   = 1'b1;
      tick();
      start = 1'b0;
      flush = 1'b0;
      chk("sf_busy", {31'b0, busy}, 32'd0);
      tick();
      chk("sf_done", {31'b0, done}, 32'd0);
      chk("sf_result", result, keep);

      // Start while busy is ignored.
      funct3  = 3'b101;
      rs1_val = 32'd100;
      rs2_val = 32'd7;
      start   = 1'b1;
      tick();
      start = 1'b0;
      lat   = 1;
      for (int k = 1; k < 5; k++) begin
         tick();
         lat++;
      end
      funct3  = 3'b000;
      rs1_val = 32'd3;
      rs2_val = 32'd3;
      start   = 1'b1;
      tick();
      lat++;
      start = 1'b0;
      while (!done && lat < 60) begin
         tick();
         lat++;
      end
      chk("ign_latency", lat, 33);
      chk("ign_result", result, 32'd14);
      tick();

      // MUL issued on the DONE cycle of a DIV.
      run_op(3'b100, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
      chk("b2b_div_latency", lat, 33);
      chk("b2b_div_result", result, 32'hFFFF_FFFD);
      funct3  = 3'b000;
      rs1_val = 32'd7;
      rs2_val = 32'hFFFF_FFFD;
      start   = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_mul_busy", {31'b0, busy}, 32'd1);
      chk("b2b_mul_done_early", {31'b0, done}, 32'd0);
      tick();
      chk("b2b_mul_done", {31'b0, done}, 32'd1);
      chk("b2b_mul_result", result, 32'hFFFF_FFEB);
      tick();

      // Reset twenty edges into a divide.
      funct3  = 3'b100;
      rs1_val = 32'd1000;
      rs2_val = 32'd3;
      start   = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k < 20; k++) tick();
      chk("rst_busy_before", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (done) seen = 1'b1;
         tick();
      end
      chk("rst_no_done", {31'b0, seen}, 32'd0);

      run_op(3'b100, 32'd1000, 32'd3, lat, bcnt);
      chk("post_rst_latency", lat, 33);
      chk("post_rst_result", result, 32'd333);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
